// File: rtl/dht11_emu.sv
// DHT11 sensor emulator: responder end of the single-wire DHT11 link.
// Detects a host start pulse, then sends the acknowledge and a 40-bit frame.
//
// Ports:
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   dht11_data           open-drain line (drives 0 or releases to z)
//   humi_int, humi_deci  humidity bytes
//   temp_int, temp_deci  temperature bytes
//   busy                 high from start acceptance until frame release
//   frame_done           one-cycle pulse when the frame completes
module dht11_emu #(
    parameter int CNT_US       = 50,
    parameter int START_MIN_US = 18000,
    parameter int RESP_DLY_US  = 30
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    inout  wire        dht11_data,
    input  logic [7:0] humi_int,
    input  logic [7:0] humi_deci,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_deci,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        WAIT_REL,
        ACK_LOW,
        ACK_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } state_t;

    localparam int PW = (CNT_US > 1) ? $clog2(CNT_US) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(CNT_US - 1);
    localparam logic [14:0]   START_MIN = 15'(START_MIN_US);
    localparam logic [14:0]   RESP_DLY  = 15'(RESP_DLY_US);

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] pre;
    logic [14:0]   us;
    logic [14:0]   dur;
    logic [2:0]    sync;
    logic [39:0]   sr;
    logic [5:0]    bit_cnt;
    logic [7:0]    csum;
    logic          drv;
    logic          tick;
    logic          step;
    logic          fall;
    logic          rise;
    logic          accept;
    logic          shift;
    logic          fd_nx;

    // Open-drain: only ever pull low.
    assign dht11_data = drv ? 1'b0 : 1'bz;

    // sync[1:0] synchronize, sync[2] holds the previous value for edges.
    assign fall = sync[2] & ~sync[1];
    assign rise = ~sync[2] & sync[1];

    assign csum = humi_int + humi_deci + temp_int + temp_deci;
    assign tick = (pre == PRE_MAX);

    // Length of the current state in microseconds.
    always_comb begin
        dur = 15'h7fff;
        unique case (state)
            WAIT_REL:          dur = RESP_DLY;
            ACK_LOW, ACK_HIGH: dur = 15'd80;
            BIT_LOW, END_LOW:  dur = 15'd50;
            BIT_HIGH:          dur = sr[39] ? 15'd70 : 15'd26;
            default:           dur = 15'h7fff;
        endcase
    end

    // Last tick of the state: leaving now gives exactly dur*CNT_US cycles.
    assign step = tick && (us == dur - 15'd1);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        shift    = 1'b0;
        fd_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) state_nx = HOST_LOW;
            end
            HOST_LOW: begin
                if (rise) begin
                    if (us >= START_MIN) begin
                        accept   = 1'b1;
                        state_nx = WAIT_REL;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            WAIT_REL: begin
                if (step) state_nx = ACK_LOW;
            end
            ACK_LOW: begin
                if (step) state_nx = ACK_HIGH;
            end
            ACK_HIGH: begin
                if (step) state_nx = BIT_LOW;
            end
            BIT_LOW: begin
                if (step) state_nx = BIT_HIGH;
            end
            BIT_HIGH: begin
                if (step) begin
                    shift    = 1'b1;
                    state_nx = (bit_cnt == 6'd39) ? END_LOW : BIT_LOW;
                end
            end
            END_LOW: begin
                if (step) begin
                    fd_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs are registered from the next state so the line never glitches.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            drv        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            drv        <= (state_nx == ACK_LOW) ||
                          (state_nx == BIT_LOW) ||
                          (state_nx == END_LOW);
            busy       <= (state_nx != IDLE) &&
                          (state_nx != HOST_LOW);
            frame_done <= fd_nx;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], dht11_data};
        end
    end

    // Prescaler and saturating microsecond counter restart on each transition.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pre <= '0;
            us  <= '0;
        end else if (state_nx != state) begin
            pre <= '0;
            us  <= '0;
        end else if (tick) begin
            pre <= '0;
            if (us != 15'h7fff) us <= us + 15'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            sr      <= {humi_int, humi_deci, temp_int, temp_deci, csum};
            bit_cnt <= '0;
        end else if (shift) begin
            sr      <= {sr[38:0], 1'b0};
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

endmodule

// File: tb/tb_dht11_emu.sv
// Testbench for dht11_emu: host start pulses on a pulled-up line,
// a line monitor decoding frames and a scoreboard of expected frames.
module tb_dht11_emu;

    localparam int C     = 2;
    localparam int SMIN  = 150;
    localparam int RESP  = 30;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] humi_int, humi_deci, temp_int, temp_deci;
    logic       busy, frame_done;
    wire        dht11_data;

    assign dht11_data = host_low ? 1'b0 : 1'bz;
    pullup (dht11_data);

    dht11_emu #(
        .CNT_US(C),
        .START_MIN_US(SMIN),
        .RESP_DLY_US(RESP)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .dht11_data(dht11_data),
        .humi_int(humi_int),
        .humi_deci(humi_deci),
        .temp_int(temp_int),
        .temp_deci(temp_deci),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    logic [39:0] exp_q[$];

    int frames = 0;
    int busy_rises = 0;
    int mon_k = -1;

    task automatic chk(input string nm, input longint act,
                       input longint exp, input longint tol);
        longint d;
        d = act - exp;
        checks++;
        if (d < -tol || d > tol) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line monitor: measures run lengths and decodes bits.
    logic        l_prev = 1'b1;
    logic        busy_q = 1'b0;
    logic        fd_q = 1'b0;
    logic        active = 1'b0;
    int          run = 0;
    int          since = 0;
    int          nbits = 0;
    logic [39:0] bits = '0;

    always @(negedge sys_clk) begin
        logic        l;
        logic        b;
        logic [39:0] e;
        l = dht11_data;
        if (sys_rst) begin
            active = 1'b0;
            mon_k  = -1;
            run    = 0;
        end else begin
            if (fd_q) chk("frame_done_width", frame_done, 0, 0);
            if (busy && !busy_q) begin
                active = 1'b1;
                mon_k  = -1;
                since  = 0;
                bits   = '0;
                nbits  = 0;
                busy_rises++;
            end else if (active && mon_k < 0) begin
                since++;
            end
            if (l != l_prev) begin
                if (active) begin
                    if (mon_k < 0) begin
                        chk("resp_delay", since, RESP*C, 1);
                    end else if (mon_k < 2) begin
                        chk("ack_len", run, 80*C, 1);
                    end else if (mon_k % 2 == 0) begin
                        chk("low_len", run, 50*C, 1);
                    end else begin
                        b = (run > 48*C);
                        chk("high_len", run, b ? 70*C : 26*C, 1);
                        bits = {bits[38:0], b};
                        nbits++;
                    end
                    mon_k++;
                end
                run = 1;
            end else begin
                run++;
            end
            if (frame_done) begin
                frames++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", frames, 0, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_bits", bits, e, 0);
                    chk("bit_count", nbits, 40, 0);
                    chk("busy_at_done", busy, 0, 0);
                end
                active = 1'b0;
            end
        end
        l_prev = l;
        busy_q = busy;
        fd_q   = frame_done;
    end

    task automatic host_start(input int us_len);
        @(posedge sys_clk);
        #1 host_low = 1'b1;
        repeat (us_len*C) @(posedge sys_clk);
        #1 host_low = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (frames < n && t < 15000) begin
            @(posedge sys_clk);
            t++;
        end
        chk("frame_timeout", frames, n, 0);
        repeat (20*C) @(posedge sys_clk);
    endtask

    task automatic set_bytes(input logic [7:0] a, b, c, d);
        humi_int  = a;
        humi_deci = b;
        temp_int  = c;
        temp_deci = d;
    endtask

    initial begin
        int t;
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        repeat (4) @(posedge sys_clk);
        #3 sys_rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0, 0);
        chk("rst_done", frame_done, 0, 0);
        chk("rst_line", dht11_data, 1, 0);
        repeat (4) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (10) @(posedge sys_clk);

        exp_q.push_back({8'h37, 8'h00, 8'h19, 8'h05, 8'h55});
        host_start(180);
        wait_frames(1);

        host_start(100);
        repeat (300*C) @(posedge sys_clk);
        #1;
        chk("short_busy", busy, 0, 0);
        chk("short_line", dht11_data, 1, 0);
        chk("short_rises", busy_rises, 1, 0);
        chk("short_frames", frames, 1, 0);

        set_bytes(8'hff, 8'hff, 8'hff, 8'hff);
        exp_q.push_back({8'hff, 8'hff, 8'hff, 8'hff, 8'hfc});
        host_start(180);
        wait_frames(2);

        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        host_start(180);
        t = 0;
        while (mon_k != 5 && t < 3000) begin
            @(posedge sys_clk);
            t++;
        end
        chk("abort_reach_bit", mon_k, 5, 0);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0, 0);
        chk("abort_line", dht11_data, 1, 0);
        #4 sys_rst = 1'b0;
        repeat (200*C) @(posedge sys_clk);
        chk("abort_frames", frames, 2, 0);

        exp_q.push_back({8'h37, 8'h00, 8'h19, 8'h05, 8'h55});
        host_start(180);
        repeat (1000*C) @(posedge sys_clk);
        temp_int = 8'h20;
        wait_frames(3);

        exp_q.push_back({8'h37, 8'h00, 8'h20, 8'h05, 8'h5c});
        host_start(180);
        wait_frames(4);

        chk("queue_empty", exp_q.size(), 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
